load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage placed directly downstream of the execute stage. Takes the ALU-computed effective address and forwarded store data for a load/store and runs a request/grant/response handshake with the data-memory port. Stalls the pipeline until the access completes, then returns byte-aligned, sign/zero-extended load data for writeback. Misaligned and illegal-size accesses are flagged without touching the bus.

## Interface
- `XLEN`, 32: datapath and address width (only 32 supported).
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous active-low reset.
- `memEn`  in  1  EX/MEM register holds a load or store.
- `memWr`  in  1  1 = store, 0 = load.
- `funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  effective address (execute `aluOut`).
- `storeData`  in  32  forwarded rs2 value.
- `stall`  out  1  holds all upstream pipeline registers.
- `loadData`  out  32  aligned, extended load result.
- `accessFault`  out  1  misaligned or illegal funct3; one-cycle pulse.
- `dmemReq`  out  1  bus request.
- `dmemWe`  out  1  write enable.
- `dmemAddr`  out  32  word address, `addr[31:2]`,2'b00.
- `dmemWdata`  out  32  lane-replicated store data.
- `dmemBe`  out  4  byte enables.
- `dmemGnt`  in  1  request accepted this cycle.
- `dmemRvalid`  in  1  read data valid.
- `dmemRdata`  in  32  read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- IDLE: if `memEn` and access legal → capture `memWr`, `funct3`, `addr[1:0]`, bus fields into registers. Go to REQ. `stall`=1 combinationally this cycle.
- IDLE with `memEn` and illegal access: `accessFault`=1 combinationally, `stall`=0, no request, stay IDLE.
- Illegal access is any of: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0; funct3 ∈ {011,110,111}.
- REQ: `dmemReq`=1. `dmemWe`/`dmemAddr`/`dmemWdata`/`dmemBe` come from registers and stay stable until `dmemGnt`. On gnt, a store goes to DONE and a load goes to WAIT. `dmemRvalid` is ignored in REQ.
- WAIT: `dmemReq`=0. On `dmemRvalid`, register the aligned/extended `dmemRdata` into `loadData` and go to DONE.
- DONE: `stall`=0 for one cycle so the pipeline advances. `memEn` in DONE belongs to the completed op and is ignored. Next state is IDLE.
- `stall` = (IDLE & `memEn` & legal) | REQ | WAIT.
- Store lanes:
  - B: `dmemWdata`={4{d[7:0]}}, `dmemBe`=4'b0001<<addr[1:0].
  - H: `dmemWdata`={2{d[15:0]}}, `dmemBe`=4'b0011<<{addr[1],1'b0}.
  - W: `dmemWdata`=d, `dmemBe`=4'b1111.
- Load align: take `dmemRdata`>>(8·addr[1:0]). B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- `loadData` holds its last value until the next load completes. Stores do not change it.
- `dmemRvalid` outside WAIT is dropped. This includes stale responses after reset.

## Timing
- Reset values: state IDLE; `stall`, `accessFault`, `dmemReq`, `dmemWe`=0; `dmemAddr`, `dmemWdata`, `loadData`=0; `dmemBe`=0.
- Reset is asynchronous. Asserting it mid-access drops `dmemReq` immediately and abandons the access.
- Minimum store: 2 stall cycles (IDLE, REQ with gnt), DONE on cycle 2.
- Minimum load: 3 stall cycles (IDLE, REQ with gnt, WAIT with rvalid), `loadData` valid in DONE, cycle 3.
- Each cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- The memory never returns `dmemRvalid` in the same cycle as `dmemGnt`.
- Back-to-back accesses: the next op is sampled in IDLE, the cycle after DONE.

## Structure
- `types.vh` gains:
  - state encodings `LSU_IDLE`/`LSU_REQ`/`LSU_WAIT`/`LSU_DONE`.
  - funct3 size constants `MEM_B`/`MEM_H`/`MEM_W`/`MEM_BU`/`MEM_HU`.
- One combinational sub-module, `load_align`, with inputs (rdata, funct3, addr[1:0]) and output the extended 32-bit word. It is reused by any future load path.
- Store-lane generation and the FSM stay in the top module.

## Test plan
- LB at addr 0x103, rdata 0x80112233, gnt and rvalid at minimum latency → `loadData`=0xFFFFFF80 in cycle 3, `stall` high cycles 0–2.
- SH storeData 0x0000BEEF at 0x202, gnt held low 2 cycles → `dmemBe`=1100, `dmemWdata`=0xBEEFBEEF stable throughout REQ, `dmemAddr`=0x200, DONE 2 cycles later than minimum.
- LW at 0x006 → `accessFault` pulse, `stall`=0, `dmemReq` never asserts; funct3=011 gives the same result.
- LHU at 0x002, rdata 0x9ABC1234 → `loadData`=0x00009ABC; LH gives 0xFFFF9ABC.
- `rstn` low during WAIT, then spurious `dmemRvalid` after release → FSM is IDLE, `loadData`=0, response ignored.
- SW then LW back-to-back to 0x40 → second request issues the cycle after the first DONE, and the load returns the stored word.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: FSM state encodings, funct3 size codes and the access legality rule.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Bytes are always legal, halves need even addresses, words need word alignment.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
    return (f3 == MEM_B || f3 == MEM_BU) ||
           ((f3 == MEM_H || f3 == MEM_HU) && !off[0]) ||
           (f3 == MEM_W && off == 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_align: shifts a read word down to the accessed lane and sign/zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    sh   = rdata >> {addr, 3'b000};
    data = funct3 == MEM_B  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == MEM_H  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == MEM_BU ? {24'b0, sh[7:0]} :
           funct3 == MEM_HU ? {16'b0, sh[15:0]} : sh;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running a req/gnt/rvalid handshake with the data port.
// Stalls the pipeline while an access is in flight; flags misaligned/illegal accesses without a bus cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            memEn,
  input  logic            memWr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            stall,
  output logic [XLEN-1:0] loadData,
  output logic            accessFault,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [XLEN-1:0] dmemWdata,
  output logic [3:0]      dmemBe,
  input  logic            dmemGnt,
  input  logic            dmemRvalid,
  input  logic [XLEN-1:0] dmemRdata
);

  lsu_state_e      state, state_nxt;
  logic            legal, start, we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] wdata_nxt, aligned;
  logic [3:0]      be_nxt;

  assign legal = access_legal(funct3, addr[1:0]);
  assign start = state == LSU_IDLE && memEn && legal;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= LSU_IDLE;
    else       state <= state_nxt;

  always_comb
    state_nxt = state == LSU_IDLE ? (start ? LSU_REQ : LSU_IDLE) :
                state == LSU_REQ  ? (dmemGnt ? (we_q ? LSU_DONE : LSU_WAIT) : LSU_REQ) :
                state == LSU_WAIT ? (dmemRvalid ? LSU_DONE : LSU_WAIT) : LSU_IDLE;

  always_comb begin
    stall       = start || state == LSU_REQ || state == LSU_WAIT;
    accessFault = state == LSU_IDLE && memEn && !legal;
    dmemReq     = state == LSU_REQ;
    dmemWe      = dmemReq && we_q;
  end

  // Lanes are replicated so the memory can pick any byte/half by enables alone.
  always_comb begin
    wdata_nxt = funct3[1:0] == 2'b00 ? {4{storeData[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{storeData[15:0]}} : storeData;
    be_nxt    = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  end

  load_align u_align (
    .rdata  (dmemRdata),
    .funct3 (f3_q),
    .addr   (off_q),
    .data   (aligned)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      dmemAddr  <= '0;
      dmemWdata <= '0;
      dmemBe    <= 4'b0;
      loadData  <= '0;
    end else begin
      if (start) begin
        we_q      <= memWr;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        dmemAddr  <= {addr[XLEN-1:2], 2'b00};
        dmemWdata <= wdata_nxt;
        dmemBe    <= be_nxt;
      end
      if (state == LSU_WAIT && dmemRvalid) loadData <= aligned;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench with a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        memEn = 1'b0, memWr = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'b0, storeData = 32'b0;
  logic        dmemGnt = 1'b0, dmemRvalid = 1'b0;
  logic [31:0] dmemRdata = 32'b0;
  logic        stall, accessFault, dmemReq, dmemWe;
  logic [31:0] loadData, dmemAddr, dmemWdata;
  logic [3:0]  dmemBe;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .memEn(memEn), .memWr(memWr), .funct3(funct3),
    .addr(addr), .storeData(storeData), .stall(stall), .loadData(loadData),
    .accessFault(accessFault), .dmemReq(dmemReq), .dmemWe(dmemWe),
    .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemBe(dmemBe),
    .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          we;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0, checks = 0;
  logic [7:0]  memb[64];
  logic [7:0]  refb[64];
  logic [31:0] last_ld = 32'b0;
  int          g_force = -1, r_force = -1, g_wait = 0, r_wait = 0, gcnt = 0, rcnt = 0;
  bit          rd_pend = 0, req_seen = 0, lpend = 0, lchk = 0;
  logic [31:0] rd_word = 32'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sizes, lanes and extension computed from byte arithmetic on refb.
  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e);
    int sz;
    logic [31:0] v;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e.fault = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (int'(a[1:0]) % sz) != 0;
    e.we    = wr;
    e.waddr = a & ~32'd3;
    e.be    = 4'(((1 << sz) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
    v = 32'b0;
    if (!e.fault && wr)
      for (int i = 0; i < sz; i++) refb[int'(a[5:0]) + i] = d[8*i +: 8];
    if (!e.fault && !wr) begin
      for (int i = 0; i < sz; i++) v[8*i +: 8] = refb[int'(a[5:0]) + i];
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 1);
      last_ld = v;
    end
    e.ld = last_ld;
  endtask

  // Memory port: random grant/response delays plus spurious rvalid while no read is pending.
  initial forever begin
    @(negedge clk);
    dmemGnt = 1'b0;
    dmemRvalid = 1'b0;
    dmemRdata = $urandom;
    if (rd_pend) begin
      if (rcnt == 0) begin
        dmemRvalid = 1'b1;
        dmemRdata = rd_word;
        rd_pend = 0;
      end else begin
        rcnt--;
        r_wait++;
      end
    end else if (dmemReq) begin
      if (!req_seen) begin
        req_seen = 1;
        gcnt = g_force >= 0 ? g_force : int'($urandom_range(0, 3));
        g_wait = 0;
      end
      if (gcnt == 0) begin
        dmemGnt = 1'b1;
        req_seen = 0;
        if (dmemWe) begin
          for (int i = 0; i < 4; i++)
            if (dmemBe[i]) memb[{dmemAddr[5:2], 2'(i)}] = dmemWdata[8*i +: 8];
        end else begin
          rd_pend = 1;
          rcnt = r_force >= 0 ? r_force : int'($urandom_range(0, 3));
          r_wait = 0;
          for (int i = 0; i < 4; i++) rd_word[8*i +: 8] = memb[{dmemAddr[5:2], 2'(i)}];
        end
      end else begin
        gcnt--;
        g_wait++;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      dmemRvalid = 1'b1;
    end
  end

  // Monitor: compares every bus request, fault pulse and completed load against the queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rstn) begin
      if (lchk) begin
        lchk = 0;
        if (sb.size() == 0) chk("load_queue_empty", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("load_data", loadData, e.ld);
          chk("done_stall", {31'b0, stall}, 32'd0);
        end
      end
      if (accessFault) begin
        if (sb.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("fault_expected", {31'b0, e.fault}, 32'd1);
          chk("fault_no_req", {31'b0, dmemReq}, 32'd0);
          chk("fault_no_stall", {31'b0, stall}, 32'd0);
        end
      end
      if (dmemReq) begin
        if (sb.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          e = sb[0];
          chk("req_not_fault", {31'b0, e.fault}, 32'd0);
          chk("req_we", {31'b0, dmemWe}, {31'b0, e.we});
          chk("req_addr", dmemAddr, e.waddr);
          chk("req_be", {28'b0, dmemBe}, {28'b0, e.be});
          if (e.we) chk("req_wdata", dmemWdata, e.wdata);
          if (dmemGnt) begin
            if (e.we) begin
              void'(sb.pop_front());
              chk("store_keeps_ld", loadData, e.ld);
            end else lpend = 1;
          end
        end
      end
      if (lpend && dmemRvalid && !dmemReq) begin
        lpend = 0;
        lchk = 1;
      end
    end
  end

  task automatic idle(input int n);
    memEn = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the op's last cycle.
  task automatic do_op(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int cyc, exp_cyc;
    memEn = 1'b1;
    memWr = wr;
    funct3 = f3;
    addr = a;
    storeData = d;
    model(wr, f3, a, d, e);
    sb.push_back(e);
    #1;
    if (e.fault) begin
      chk("fault_pulse", {31'b0, accessFault}, 32'd1);
      @(negedge clk);
      return;
    end
    chk("issue_stall", {31'b0, stall}, 32'd1);
    chk("issue_no_req", {31'b0, dmemReq}, 32'd0);
    cyc = 1;
    @(negedge clk);
    #1;
    chk("req_next_cycle", {31'b0, dmemReq}, 32'd1);
    while (stall && cyc < 60) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    if (cyc >= 60) chk("stall_timeout", 32'd1, 32'd0);
    exp_cyc = wr ? 2 + g_wait : 3 + g_wait + r_wait;
    chk("stall_cycles", cyc, exp_cyc);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      memb[i] = 8'($urandom);
      refb[i] = memb[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fault", {31'b0, accessFault}, 32'd0);
    chk("rst_req", {31'b0, dmemReq}, 32'd0);
    chk("rst_we", {31'b0, dmemWe}, 32'd0);
    chk("rst_addr", dmemAddr, 32'd0);
    chk("rst_wdata", dmemWdata, 32'd0);
    chk("rst_be", {28'b0, dmemBe}, 32'd0);
    chk("rst_load", loadData, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    g_force = 0;
    r_force = 0;
    {memb[3], memb[2], memb[1], memb[0]} = 32'h80112233;
    {refb[3], refb[2], refb[1], refb[0]} = 32'h80112233;
    do_op(0, 3'b000, 32'h103, 32'h0);
    g_force = 2;
    do_op(1, 3'b001, 32'h202, 32'h0000BEEF);
    g_force = 0;
    do_op(0, 3'b010, 32'h006, 32'h0);
    do_op(0, 3'b011, 32'h000, 32'h0);
    {memb[3], memb[2], memb[1], memb[0]} = 32'h9ABC1234;
    {refb[3], refb[2], refb[1], refb[0]} = 32'h9ABC1234;
    do_op(0, 3'b101, 32'h002, 32'h0);
    do_op(0, 3'b001, 32'h002, 32'h0);
    idle(2);

    g_force = -1;
    r_force = -1;
    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom), 3'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    // Reset while waiting for read data; the late response must be dropped.
    g_force = 0;
    r_force = 6;
    memEn = 1'b1;
    memWr = 1'b0;
    funct3 = 3'b010;
    addr = 32'h10;
    begin
      exp_t e;
      model(0, 3'b010, 32'h10, 32'h0, e);
      sb.push_back(e);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("wait_stall", {31'b0, stall}, 32'd1);
    chk("wait_no_req", {31'b0, dmemReq}, 32'd0);
    #2;
    rstn = 1'b0;
    memEn = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, dmemReq}, 32'd0);
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    chk("async_rst_load", loadData, 32'd0);
    sb.delete();
    lpend = 0;
    lchk = 0;
    last_ld = 32'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("stale_rvalid_load", loadData, 32'd0);
    chk("stale_rvalid_stall", {31'b0, stall}, 32'd0);
    chk("stale_rvalid_req", {31'b0, dmemReq}, 32'd0);
    @(negedge clk);

    r_force = 0;
    do_op(1, 3'b010, 32'h40, 32'hCAFEF00D);
    do_op(0, 3'b010, 32'h40, 32'h0);
    idle(4);
    if (sb.size() != 0) chk("queue_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
